// File: rtl/serial_defs_pkg.sv
// rtl/serial_defs_pkg.sv - shared state encoding, line levels and sizing helper for the serial TX path
package serial_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width that never collapses to zero bits for a range of one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_shifter.sv
// rtl/piso_shifter.sv - parallel-load shift register with selectable output end
module piso_shifter #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 shift_en,
    input  logic                 dir,
    input  logic [DATA_BITS-1:0] d,
    output logic                 q_out
);

    logic [DATA_BITS-1:0] sh_q;
    logic [DATA_BITS-1:0] sh_d;

    // Load wins over shift; shifting moves bits toward the output end with zero fill.
    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = d;
        end else if (shift_en) begin
            if (dir) begin
                sh_d = {sh_q[DATA_BITS-2:0], 1'b0};
            end else begin
                sh_d = {1'b0, sh_q[DATA_BITS-1:1]};
            end
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q_out = dir ? sh_q[DATA_BITS-1] : sh_q[0];

endmodule

// File: rtl/serial_tx_ctrl.sv
// rtl/serial_tx_ctrl.sv - start/data/stop frame sequencer driving a PISO shifter onto a serial line
module serial_tx_ctrl
    import serial_defs::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 msb_first,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int BW = cnt_width(DATA_BITS);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            msb_q, msb_d;
    logic            done_q, done_d;
    logic            load;
    logic            shift_en;
    logic            sh_out;
    logic            bit_end;

    assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

    piso_shifter #(
        .DATA_BITS (DATA_BITS)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift_en (shift_en),
        .dir      (msb_q),
        .d        (data_in),
        .q_out    (sh_out)
    );

    // Next-state logic: accept in IDLE, advance on each bit boundary, pulse done on leaving STOP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        msb_d    = msb_q;
        done_d   = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    msb_d   = msb_first;
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    bit_d    = bit_q + BW'(1);
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters, latched bit order and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            msb_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            msb_q   <= msb_d;
            done_q  <= done_d;
        end
    end

    // Line level is a pure decode of state and shifter output.
    always_comb begin
        tx = LINE_IDLE;
        case (state_q)
            ST_START: tx = START_BIT;
            ST_DATA:  tx = sh_out;
            ST_STOP:  tx = STOP_BIT;
            default:  tx = LINE_IDLE;
        endcase
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// tb/tb_serial_tx_ctrl.sv - scoreboard bench for serial_tx_ctrl at 4 and 1 clocks per bit
module tb_serial_tx_ctrl;

    typedef struct {
        logic [9:0] frame;
        int         acc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       in_valid0, in_valid1;
    logic       in_ready0, in_ready1;
    logic [7:0] data0, data1;
    logic       msb0, msb1;
    logic       tx0, tx1;
    logic       busy0, busy1;
    logic       done0, done1;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];

    bit         active[2];
    bit         done_pend[2];
    int         pos[2];
    logic [9:0] fr[2];
    logic       m_t, m_b, m_d, m_r;
    int         m_cp, m_slot;
    bit         m_have;
    exp_t       m_e;

    serial_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
        .data_in(data0), .msb_first(msb0), .tx(tx0), .busy(busy0), .done(done0)
    );

    serial_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .data_in(data1), .msb_first(msb1), .tx(tx1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: per DUT, follow frames as they appear and compare against the queued expectations.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_t  = (k == 0) ? tx0 : tx1;
            m_b  = (k == 0) ? busy0 : busy1;
            m_d  = (k == 0) ? done0 : done1;
            m_r  = (k == 0) ? in_ready0 : in_ready1;
            m_cp = (k == 0) ? 4 : 1;
            if (reset) begin
                active[k]    = 1'b0;
                done_pend[k] = 1'b0;
                chk("reset_tx", m_t, 1'b1);
                chk("reset_busy", m_b, 1'b0);
                chk("reset_done", m_d, 1'b0);
                chk("reset_ready", m_r, 1'b1);
            end else begin
                if (!active[k]) begin
                    if (done_pend[k]) begin
                        chk("done_pulse", m_d, 1'b1);
                        chk("ready_in_done_cycle", m_r, 1'b1);
                        done_pend[k] = 1'b0;
                    end else begin
                        chk("no_spurious_done", m_d, 1'b0);
                    end
                    if (m_b) begin
                        m_have = 1'b0;
                        if (k == 0 && q0.size() > 0) begin
                            m_e = q0.pop_front();
                            m_have = 1'b1;
                        end
                        if (k == 1 && q1.size() > 0) begin
                            m_e = q1.pop_front();
                            m_have = 1'b1;
                        end
                        if (!m_have) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_frame: dut%0d busy with no queued word at cycle %0d", k, cyc);
                        end else begin
                            active[k] = 1'b1;
                            pos[k]    = 0;
                            fr[k]     = m_e.frame;
                            chk_int("frame_start_cycle", cyc, m_e.acc);
                        end
                    end else begin
                        chk("idle_tx_high", m_t, 1'b1);
                    end
                end
                if (active[k]) begin
                    m_slot = pos[k] / m_cp;
                    chk($sformatf("dut%0d_tx_slot%0d", k, m_slot), m_t, fr[k][9 - m_slot]);
                    chk("busy_in_frame", m_b, 1'b1);
                    chk("ready_low_in_frame", m_r, 1'b0);
                    chk("done_low_in_frame", m_d, 1'b0);
                    pos[k]++;
                    if (pos[k] == 10 * m_cp) begin
                        active[k]    = 1'b0;
                        done_pend[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Present a word to DUT k (called just after a rising edge) and queue its expected frame at accept.
    task automatic send(input int k, input logic [7:0] d, input logic m, input logic [9:0] frame,
                        input bit keep, output int acc_cyc);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        acc_cyc = -1;
        if (k == 0) begin in_valid0 = 1'b1; data0 = d; msb0 = m; end
        else        begin in_valid1 = 1'b1; data1 = d; msb1 = m; end
        for (int i = 0; i < 200 && !ok; i++) begin
            if ((k == 0) ? in_ready0 : in_ready1) begin
                @(posedge clk);
                #2;
                acc_cyc = cyc;
                e.frame = frame;
                e.acc   = cyc;
                if (k == 0) q0.push_back(e); else q1.push_back(e);
                ok = 1'b1;
            end else begin
                @(posedge clk);
                #2;
            end
        end
        if (!ok) chk("accept_timeout", 1'b0, 1'b1);
        if (!keep) begin
            if (k == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
        end
    endtask

    task automatic wait_idle(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #2;
            if (!active[k] && !done_pend[k] && ((k == 0) ? q0.size() : q1.size()) == 0) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #2;
    endtask

    int a0, a1;

    initial begin
        reset = 1'b1;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00; msb0 = 1'b0; msb1 = 1'b0;
        #1;
        chk("async_reset_tx", tx0, 1'b1);
        chk("async_reset_ready", in_ready0, 1'b1);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;

        // 8'hF0 LSB first
        send(0, 8'hF0, 1'b0, 10'b0_00001111_1, 1'b0, a0);
        wait_idle(0);

        // 8'hF0 MSB first
        send(0, 8'hF0, 1'b1, 10'b0_11110000_1, 1'b0, a0);
        wait_idle(0);

        // in_valid held, data changed mid-frame, back-to-back accept in the done cycle
        send(0, 8'hF0, 1'b0, 10'b0_00001111_1, 1'b1, a0);
        repeat (5) @(posedge clk);
        #2;
        data0 = 8'h3C;
        send(0, 8'h3C, 1'b0, 10'b0_00111100_1, 1'b0, a1);
        chk_int("back_to_back_period", a1 - a0, 41);
        wait_idle(0);

        // reset in the middle of a frame, then a clean frame
        send(0, 8'hF0, 1'b0, 10'b0_00001111_1, 1'b0, a0);
        repeat (19) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midframe_reset_tx", tx0, 1'b1);
        chk("midframe_reset_busy", busy0, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
        send(0, 8'hA5, 1'b0, 10'b0_10100101_1, 1'b0, a0);
        wait_idle(0);

        // one clock per bit
        send(1, 8'h01, 1'b0, 10'b0_10000000_1, 1'b0, a0);
        wait_idle(1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
